// File: rtl/regfile_pkg.sv
// Shared register-file types and default geometry for decoder, ALU and regfile.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam int RF_DEF_WIDTH = 16;
    localparam int RF_DEF_NREGS = 16;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps zeroes through the array after reset or clear_req, gates writes.
// Latency: one register cleared per cycle, ready after NREGS cycles.
// Backpressure: none; writes arriving while not accepting are flagged for wr_drop.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = RF_DEF_NREGS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_req,
    input  logic                     wr_en,
    output logic                     ready,
    output logic                     clr_we,
    output logic [$clog2(NREGS)-1:0] clr_addr,
    output logic                     wr_ok,
    output logic                     wr_discard
);

    localparam int REGBITS = $clog2(NREGS);

    rf_state_t          state_q, state_d;
    logic [REGBITS-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter wraps to 0 on the last clear because NREGS is a power of two.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == REGBITS'(NREGS - 1)) state_d = RF_READY;
            end
            RF_READY: begin
                if (clear_req) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = RF_CLEAR;
        endcase
    end

    always_comb begin
        ready      = (state_q == RF_READY);
        clr_we     = (state_q == RF_CLEAR);
        clr_addr   = cnt_q;
        wr_ok      = wr_en && (state_q == RF_READY) && !clear_req;
        wr_discard = wr_en && ((state_q == RF_CLEAR) || clear_req);
    end

endmodule

// File: rtl/regfile_mp.sv
// Two-read/one-write register file with self-clearing sweep; REGFILE_BYPASS_EN selects write-first reads.
// Latency: reads 1 cycle (registered). Backpressure: none; writes outside READY are dropped and flagged on wr_drop.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_DEF_WIDTH,
    parameter int NREGS = RF_DEF_NREGS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_req,
    input  logic                     wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(NREGS)-1:0] rd_addr1,
    input  logic [$clog2(NREGS)-1:0] rd_addr2,
    output logic [WIDTH-1:0]         rd_data1,
    output logic [WIDTH-1:0]         rd_data2,
    output logic                     ready,
    output logic                     wr_drop
);

    localparam int REGBITS = $clog2(NREGS);

    logic               clr_we;
    logic [REGBITS-1:0] clr_addr;
    logic               wr_ok;
    logic               wr_discard;

    logic [WIDTH-1:0]   mem_q [NREGS];
    logic [WIDTH-1:0]   rd1_q, rd1_d;
    logic [WIDTH-1:0]   rd2_q, rd2_d;
    logic               drop_q;

    regfile_clear_seq #(.NREGS(NREGS)) u_clear_seq (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .wr_en      (wr_en),
        .ready      (ready),
        .clr_we     (clr_we),
        .clr_addr   (clr_addr),
        .wr_ok      (wr_ok),
        .wr_discard (wr_discard)
    );

    // Storage is deliberately not reset; the sweep provides the zero state.
    always_ff @(posedge clk) begin
        if (clr_we)     mem_q[clr_addr] <= '0;
        else if (wr_ok) mem_q[wr_addr]  <= wr_data;
    end

    always_comb begin
        rd1_d = mem_q[rd_addr1];
        rd2_d = mem_q[rd_addr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr1)) rd1_d = wr_data;
        if (wr_ok && (wr_addr == rd_addr2)) rd2_d = wr_data;
`endif
        if (clr_we) begin
            rd1_d = '0;
            rd2_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd1_q  <= '0;
            rd2_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            drop_q <= wr_discard;
        end
    end

    assign rd_data1 = rd1_q;
    assign rd_data2 = rd2_q;
    assign wr_drop  = drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: sweep timing, writes, forwarding, dropped writes, clear and reset.
module tb_regfile_mp;

    localparam int WIDTH = 16;
    localparam int NREGS = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear_req;
    logic             wr_en;
    logic [3:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [3:0]       rd_addr1;
    logic [3:0]       rd_addr2;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    logic             ready;
    logic             wr_drop;

    int errors = 0;
    int checks = 0;

    regfile_mp #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .ready     (ready),
        .wr_drop   (wr_drop)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        clear_req = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr1  = '0;
        rd_addr2  = '0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        clear_req = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 4'd1;
        wr_data   = 16'hFFFF;
        rd_addr1  = 4'd1;
        rd_addr2  = 4'd2;
        repeat (3) tick();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++;
        if (wr_drop !== 1'b0) begin errors++; $display("FAIL reset_wr_drop got=%b exp=0", wr_drop); end
        checks++;
        if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0) begin
            errors++; $display("FAIL reset_rd got=%h/%h exp=0000/0000", rd_data1, rd_data2);
        end
        wr_en = 1'b0;
        reset = 1'b1;
        for (int i = 1; i <= NREGS; i++) begin
            tick();
            checks++;
            if (ready !== (i == NREGS)) begin
                errors++; $display("FAIL sweep_ready edge=%0d got=%b exp=%b", i, ready, (i == NREGS));
            end
        end
        for (int i = 0; i < NREGS; i++) begin
            rd_addr1 = 4'(i);
            rd_addr2 = 4'(NREGS - 1 - i);
            tick();
            checks++;
            if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0) begin
                errors++; $display("FAIL post_sweep_read r%0d got=%h/%h exp=0000/0000", i, rd_data1, rd_data2);
            end
        end
    endtask

    task automatic test_write();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        rd_addr1 = 4'd3; rd_addr2 = 4'd3;
        tick();
        checks++;
        if (rd_data1 !== 16'hBEEF || rd_data2 !== 16'hBEEF) begin
            errors++; $display("FAIL write_r3 got=%h/%h exp=beef/beef", rd_data1, rd_data2);
        end
        checks++;
        if (wr_drop !== 1'b0) begin errors++; $display("FAIL write_no_drop got=%b exp=0", wr_drop); end
        rd_addr1 = 4'd4;
        tick();
        checks++;
        if (rd_data1 !== 16'h0 || rd_data2 !== 16'hBEEF) begin
            errors++; $display("FAIL read_r4_r3 got=%h/%h exp=0000/beef", rd_data1, rd_data2);
        end
    endtask

    task automatic test_same_edge();
        logic [WIDTH-1:0] exp;
`ifdef REGFILE_BYPASS_EN
        exp = 16'h1234;
`else
        exp = 16'h0000;
`endif
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
        rd_addr1 = 4'd5; rd_addr2 = 4'd5;
        tick();
        wr_en = 1'b0;
        checks++;
        if (rd_data1 !== exp || rd_data2 !== exp) begin
            errors++; $display("FAIL same_edge_r5 got=%h/%h exp=%h", rd_data1, rd_data2, exp);
        end
        tick();
        checks++;
        if (rd_data1 !== 16'h1234 || rd_data2 !== 16'h1234) begin
            errors++; $display("FAIL after_same_edge_r5 got=%h/%h exp=1234", rd_data1, rd_data2);
        end
    endtask

    task automatic test_drop_in_sweep();
        do_reset();
        repeat (4) tick();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hAAAA;
        rd_addr1 = 4'd7; rd_addr2 = 4'd7;
        tick();
        wr_en = 1'b0;
        checks++;
        if (wr_drop !== 1'b1) begin errors++; $display("FAIL sweep_drop_pulse got=%b exp=1", wr_drop); end
        checks++;
        if (rd_data1 !== 16'h0) begin errors++; $display("FAIL sweep_no_forward got=%h exp=0000", rd_data1); end
        tick();
        checks++;
        if (wr_drop !== 1'b0) begin errors++; $display("FAIL sweep_drop_end got=%b exp=0", wr_drop); end
        repeat (10) tick();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL sweep_ready16 got=%b exp=1", ready); end
        tick();
        checks++;
        if (rd_data1 !== 16'h0) begin errors++; $display("FAIL r7_after_drop got=%h exp=0000", rd_data1); end
    endtask

    task automatic test_clear_req();
        for (int i = 0; i < NREGS; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'h1000 + 16'(i);
            tick();
        end
        wr_en = 1'b0;
        rd_addr1 = 4'd9; rd_addr2 = 4'd15;
        tick();
        checks++;
        if (rd_data1 !== 16'h1009 || rd_data2 !== 16'h100F) begin
            errors++; $display("FAIL fill_read got=%h/%h exp=1009/100f", rd_data1, rd_data2);
        end
        clear_req = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hFFFF;
        rd_addr1 = 4'd2; rd_addr2 = 4'd9;
        tick();
        clear_req = 1'b0; wr_en = 1'b0;
        checks++;
        if (wr_drop !== 1'b1) begin errors++; $display("FAIL clear_drop got=%b exp=1", wr_drop); end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL clear_ready_low got=%b exp=0", ready); end
        checks++;
        if (rd_data1 !== 16'h1002 || rd_data2 !== 16'h1009) begin
            errors++; $display("FAIL clear_edge_read got=%h/%h exp=1002/1009", rd_data1, rd_data2);
        end
        for (int i = 1; i <= NREGS; i++) begin
            clear_req = (i == 8);
            tick();
            checks++;
            if (ready !== (i == NREGS)) begin
                errors++; $display("FAIL clear_sweep edge=%0d got=%b exp=%b", i, ready, (i == NREGS));
            end
        end
        clear_req = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            rd_addr1 = 4'(i); rd_addr2 = 4'(i);
            tick();
            checks++;
            if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0) begin
                errors++; $display("FAIL cleared_read r%0d got=%h/%h exp=0000", i, rd_data1, rd_data2);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (8) tick();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h0BAD;
        tick();
        wr_en = 1'b0;
        checks++;
        if (wr_drop !== 1'b1) begin errors++; $display("FAIL mid_drop_pre got=%b exp=1", wr_drop); end
        reset = 1'b0;
        #1;
        checks++;
        if (wr_drop !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset_async got=%b/%b exp=0/0", wr_drop, ready);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= NREGS; i++) begin
            tick();
            checks++;
            if (ready !== (i == NREGS)) begin
                errors++; $display("FAIL resweep edge=%0d got=%b exp=%b", i, ready, (i == NREGS));
            end
        end
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'h5A5A;
        tick();
        wr_en = 1'b0; rd_addr1 = 4'd1;
        tick();
        checks++;
        if (rd_data1 !== 16'h5A5A) begin errors++; $display("FAIL pre_reset_read got=%h exp=5a5a", rd_data1); end
        reset = 1'b0;
        #1;
        checks++;
        if (rd_data1 !== 16'h0 || ready !== 1'b0) begin
            errors++; $display("FAIL ready_reset_async got=%h/%b exp=0000/0", rd_data1, ready);
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_same_edge();
        test_drop_in_sweep();
        test_clear_req();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised register file for the CPU datapath, sitting between the instruction decoder and the ALU. It provides two synchronous read ports (BRAM-style, one-cycle latency) and one write port for ALU write-back. A built-in clear sequencer zeroes every register after reset, or on request, without an asynchronously reset storage array.

## Interface
- `WIDTH`, 16, register width in bits
- `NREGS`, 16, number of registers; power of two, ≥2
- `REGBITS`, `$clog2(NREGS)`, address width; derived localparam, not overridable

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `clear_req`  in  1  request a full re-clear; single-cycle pulse, level tolerated
- `wr_en`  in  1  write enable
- `wr_addr`  in  REGBITS  write address
- `wr_data`  in  WIDTH  write data
- `rd_addr1`, `rd_addr2`  in  REGBITS  read addresses (src/dst)
- `rd_data1`, `rd_data2`  out  WIDTH  registered read data
- `ready`  out  1  high when the array is cleared and accepting writes
- `wr_drop`  out  1  one-cycle pulse: an asserted write was discarded

## Operation
- Two states: CLEAR and READY.
- While `reset`=0: state CLEAR, clear counter 0, `rd_data1`/`rd_data2`=0, `ready`=0, `wr_drop`=0. Array contents are undefined.
- CLEAR behaviour:
  - Each rising edge writes 0 to `reg[cnt]`, then increments `cnt`.
  - On the edge that clears `reg[NREGS-1]`, go to READY. `cnt` wraps to 0.
- READY + `clear_req`=1 → CLEAR on the next edge with `cnt`=0. That edge does not clear a register.
- `clear_req` while in CLEAR: ignored. The sweep is not restarted.
- Writes:
  - A write is performed only in READY with `clear_req`=0.
  - `wr_en`=1 in CLEAR, or together with `clear_req`: the write is discarded and `wr_drop`=1 on the following cycle.
- Reads: each port samples its address at the edge and loads `reg[addr]` into `rd_dataN`.
  - In CLEAR, both read outputs load 0.
  - Both ports may address the same register.
- There is no hardwired zero register. All NREGS registers are writable.

## Timing
- Reset release: first edge clears reg 0. `ready` goes high after edge NREGS (the edge clearing `reg[NREGS-1]`), i.e. NREGS cycles.
- Read latency is 1 cycle: address at edge n → data valid after edge n.
- Write: data is stored at edge n and visible to a read sampled at edge n+1.
- Same-edge write and read of the same address: see Configuration.
- `reset` asserted mid-operation, including mid-sweep: outputs go to reset values immediately (asynchronous). A full sweep restarts after release.
- `wr_drop` is registered and is cleared to 0 on every edge without a discarded write.

## Configuration
- Macro `REGFILE_BYPASS_EN`:
  - Defined: a read port whose address equals `wr_addr` while a write is performed on the same edge loads `wr_data` (write-first forwarding).
  - Undefined: that port loads the old contents (read-first).
  - Either way, a discarded write is never forwarded.

## Structure
- Package `regfile_pkg`:
  - state enum `rf_state_t` {RF_CLEAR, RF_READY}
  - default `WIDTH`/`NREGS` constants shared with decoder and ALU
- Sub-module `regfile_clear_seq` owns:
  - the FSM and clear counter
  - outputs `ready`, `clr_we`, `clr_addr`, and the write-gating term that drives `wr_drop`
- The top level holds the array, read registers and bypass mux.

## Test plan
- Reset release, NREGS=16 → `ready`=0 for 16 cycles, then 1; reads of regs 0–15 return 0x0000.
- Write 0xBEEF to r3, then read r3 on both ports next cycle → both 0xBEEF after 1 cycle; r4 still 0.
- Same-edge write 0x1234 to r5 plus read r5:
  - with `REGFILE_BYPASS_EN` → 0x1234
  - without → previous value 0x0000
- `wr_en` during the sweep (cycle 5, r7=0xAAAA) → `wr_drop` pulses for one cycle; r7 reads 0 after `ready`.
- Fill all regs, pulse `clear_req` with a simultaneous write → write dropped with `wr_drop`=1; `ready` low for 16 cycles; all regs read 0 afterwards.
- Assert `reset` at sweep count 9 → outputs 0 immediately; after release the full 16-cycle sweep runs again.
